// File: rtl/count_checker_pkg.sv
// Shared types for the pad counter checker: FSM states and per-cycle compare classes.
package count_checker_pkg;

  typedef enum logic {HUNT, LOCKED} state_t;

  typedef enum logic [1:0] {CMP_HOLD, CMP_GOOD, CMP_BAD} cmp_t;

  // Fill counter value at which both s and prev hold post-reset pad data.
  localparam logic [1:0] FILL_DONE = 2'd3;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for an asynchronous bus, 2-cycle latency, no backpressure.
// Bits are synchronised independently; skew across bits is passed through unchanged.
module sync_2ff #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/count_checker.sv
// Locks onto a +1 pad counter sequence and counts violations while locked.
// Outputs update 2 cycles after pad capture; no backpressure, every cycle is checked.
module count_checker
  import count_checker_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned LOSS_COUNT = 2,
  parameter int unsigned ERR_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     data_in,
  input  logic                 clear_err,
  output logic                 locked,
  output logic                 err_pulse,
  output logic [ERR_WIDTH-1:0] err_count,
  output logic [WIDTH-1:0]     last_value
);

  localparam int unsigned RUN_MAX = (LOCK_COUNT > LOSS_COUNT) ? LOCK_COUNT : LOSS_COUNT;
  localparam int unsigned RUN_W   = $clog2(RUN_MAX + 1);
  localparam logic [RUN_W-1:0] LOCK_LAST = RUN_W'(LOCK_COUNT - 1);
  localparam logic [RUN_W-1:0] LOSS_LAST = RUN_W'(LOSS_COUNT - 1);

  logic [WIDTH-1:0]     s;
  logic [WIDTH-1:0]     prev;
  logic [WIDTH-1:0]     prev_inc;
  logic [1:0]           fill;
  cmp_t                 cmp;
  state_t               state, state_nx;
  logic [RUN_W-1:0]     good_run, good_nx;
  logic [RUN_W-1:0]     bad_run, bad_nx;
  logic [ERR_WIDTH-1:0] err_nx;
  logic                 pulse_nx;

  sync_2ff #(.WIDTH(WIDTH)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (data_in),
    .q   (s)
  );

  assign prev_inc = prev + 1'b1;

  always_comb begin
    cmp = CMP_HOLD;
    if (fill == FILL_DONE) begin
      if (s == prev)          cmp = CMP_HOLD;
      else if (s == prev_inc) cmp = CMP_GOOD;
      else                    cmp = CMP_BAD;
    end
  end

  always_comb begin
    state_nx = state;
    good_nx  = good_run;
    bad_nx   = bad_run;
    err_nx   = err_count;
    pulse_nx = 1'b0;
    case (state)
      HUNT: begin
        if (cmp == CMP_GOOD) begin
          if (good_run == LOCK_LAST) begin
            state_nx = LOCKED;
            good_nx  = '0;
          end else begin
            good_nx = good_run + 1'b1;
          end
        end else if (cmp == CMP_BAD) begin
          good_nx = '0;
        end
      end
      LOCKED: begin
        if (cmp == CMP_BAD) begin
          pulse_nx = 1'b1;
          if (!(&err_count)) err_nx = err_count + 1'b1;
          // The violation that causes loss of lock is still counted.
          if (bad_run == LOSS_LAST) begin
            state_nx = HUNT;
            bad_nx   = '0;
            good_nx  = '0;
          end else begin
            bad_nx = bad_run + 1'b1;
          end
        end else if (cmp == CMP_GOOD) begin
          bad_nx = '0;
        end
      end
    endcase
    // Clear wins over a coincident increment; the pulse still reports it.
    if (clear_err) err_nx = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= HUNT;
      good_run  <= '0;
      bad_run   <= '0;
      err_count <= '0;
      err_pulse <= 1'b0;
      prev      <= '0;
      fill      <= '0;
    end else begin
      state     <= state_nx;
      good_run  <= good_nx;
      bad_run   <= bad_nx;
      err_count <= err_nx;
      err_pulse <= pulse_nx;
      prev      <= s;
      if (fill != FILL_DONE) fill <= fill + 2'd1;
    end
  end

  assign locked     = (state == LOCKED);
  assign last_value = prev;

endmodule
